regfile_write_ctrl: RTL and testbench
=====================================

# regfile_write_ctrl

Write-port controller for the 32 x 32-bit register file. Arbitrates two independent writeback requesters (A: ALU/result path, B: load/memory path) onto the register file's single write port using round-robin priority. Optionally runs a post-reset scrub sequence that writes zero to every register, replacing simulation-only initialisation so the file powers up in a known state. Sits between the multi-cycle control/datapath and the register file's regwrite/addr3/wd3 inputs.

## Interface
- `NREGS`, 32, number of architectural registers; register 0 is hardwired zero
- `ADDR_W`, 5, register address width; must satisfy 2^ADDR_W >= NREGS
- `DATA_W`, 32, data width

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `a_req`  in  1  requester A has a write pending
- `a_addr`  in  ADDR_W  requester A destination register
- `a_data`  in  DATA_W  requester A write data
- `a_gnt`  out  1  requester A write accepted this cycle
- `b_req`  in  1  requester B has a write pending
- `b_addr`  in  ADDR_W  requester B destination register
- `b_data`  in  DATA_W  requester B write data
- `b_gnt`  out  1  requester B write accepted this cycle
- `rf_we`  out  1  to register file regwrite
- `rf_addr`  out  ADDR_W  to register file addr3
- `rf_wd`  out  DATA_W  to register file wd3
- `busy`  out  1  scrub in progress; no grants issued

## Operation
- States: SCRUB, RUN.
  - Reset enters SCRUB when scrub is compiled in, RUN otherwise.
- SCRUB:
  - Counter `scrub_idx` starts at 1 and advances by one per cycle.
  - Each cycle issues `rf_we`=1, `rf_addr`=`scrub_idx`, `rf_wd`=0.
  - After issuing `NREGS-1`, the FSM moves to RUN.
  - `busy`=1 throughout SCRUB; `a_gnt`=`b_gnt`=0 regardless of requests.
- RUN:
  - A request is accepted in any cycle where its req and gnt are both 1. Grant is combinational from req and the priority state.
  - Requesters hold req, addr and data stable until they see gnt.
- Arbitration:
  - Only A requesting: A granted.
  - Only B requesting: B granted.
  - Both requesting: grant goes to the requester not granted most recently.
  - `last` flop updates only on an accepted transfer. Reset value is B, so A wins the first tie.
  - At most one gnt is high per cycle.
- Accepted transfer:
  - Registered onto `rf_we`/`rf_addr`/`rf_wd` at the next edge.
  - Destination 0 is still granted (the requester completes) but is registered with `rf_we`=0. Register 0 is never written.
- No request accepted: `rf_we`=0 next cycle. `rf_addr` and `rf_wd` hold their previous values.
- Reset asserted mid-SCRUB or mid-RUN:
  - Immediately clears all state and outputs.
  - Scrub restarts from index 1 after deassertion.
  - An in-flight registered write is discarded.

## Timing
- Reset values:
  - `rf_we`=0, `rf_addr`=0, `rf_wd`=0.
  - `a_gnt`=`b_gnt`=0.
  - `busy`=1 if scrub is compiled in, else 0.
- Grant latency: 0 cycles. Gnt is visible in the same cycle req is seen, during RUN.
- Write latency: a transfer accepted at edge N appears on `rf_*` during cycle N+1, and the register file captures it at edge N+1.
- Throughput: one write per cycle. Back-to-back conflicting requests alternate A, B, A, B.
- Scrub duration: `NREGS-1` cycles (31 by default).
  - `busy` falls on the edge that issues the last scrub write (index 31).
  - Grants are possible in the cycle that write is on `rf_*`.

## Configuration
- `RFCTRL_SCRUB_EN`
  - Defined: SCRUB state, `scrub_idx` counter and `busy` behaviour as above.
  - Undefined: FSM reduces to RUN only, `busy` is tied to 0, and requests are grantable in the first cycle after reset deasserts.

## Test plan
- Scrub after reset: deassert reset, hold `a_req`=1 -> `rf_we`=1 with `rf_addr`=1..31 and `rf_wd`=0 on 31 consecutive cycles, `a_gnt`=0 until `busy`=0, then `a_gnt`=1.
- Single requester: `a_req`=1, `a_addr`=5, `a_data`=0xDEADBEEF -> `a_gnt`=1 same cycle; next cycle `rf_we`=1, `rf_addr`=5, `rf_wd`=0xDEADBEEF.
- Contention: `a_req`=`b_req`=1 held for 4 cycles with distinct addrs 3/7 -> grants A, B, A, B; `rf_addr` sequence 3, 7, 3, 7; never both gnts high.
- Zero destination: `b_req`=1, `b_addr`=0, `b_data`=0x1234 -> `b_gnt`=1, next cycle `rf_we`=0.
- Reset mid-operation: assert reset at scrub index 10 -> `rf_we`=0 and `busy`=1 immediately; after release, scrub restarts at `rf_addr`=1.
- Fairness state: A granted alone, then both request -> B granted first.

Source files
------------

// File: rtl/regfile_write_ctrl.sv
// Write-port controller for the register file: round-robin arbitration of two
// writeback requesters onto one write port, with an optional post-reset zero scrub
// (enabled by defining RFCTRL_SCRUB_EN).
module regfile_write_ctrl #(
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_gnt,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_gnt,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wd,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NREGS - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

    logic              scrubbing;
    logic [ADDR_W-1:0] scrub_idx;
    logic              grant_en;
    logic              last_b;
    logic              wr_vld_p0;
    logic [ADDR_W-1:0] wr_addr_p0;
    logic [DATA_W-1:0] wr_data_p0;

`ifdef RFCTRL_SCRUB_EN
    typedef enum logic {SCRUB, RUN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] scrub_idx_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCRUB;
            scrub_idx <= FIRST_IDX;
        end else begin
            state     <= state_nxt;
            scrub_idx <= scrub_idx_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        scrub_idx_nxt = scrub_idx;
        case (state)
            SCRUB: begin
                if (scrub_idx == LAST_IDX) begin
                    state_nxt     = RUN;
                    scrub_idx_nxt = FIRST_IDX;
                end else begin
                    scrub_idx_nxt = scrub_idx + FIRST_IDX;
                end
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = SCRUB;
        endcase
    end

    assign scrubbing = (state == SCRUB);
`else
    assign scrubbing = 1'b0;
    assign scrub_idx = '0;
`endif

    assign busy = scrubbing;

    // Grants are combinational, so they must also be held off while reset is asserted.
    assign grant_en = ~scrubbing & ~reset;

    // Returns {b, a}; on a tie the requester not granted most recently wins.
    function automatic logic [1:0] arbitrate(input logic ra, input logic rb, input logic lb);
        logic [1:0] g;
        g = 2'b00;
        if (ra && (!rb || lb)) begin
            g = 2'b01;
        end else if (rb) begin
            g = 2'b10;
        end
        return g;
    endfunction

    assign {b_gnt, a_gnt} = grant_en ? arbitrate(a_req, b_req, last_b) : 2'b00;

    // Stage p0: select the write for the next edge; address/data hold when idle.
    always_comb begin
        wr_vld_p0  = 1'b0;
        wr_addr_p0 = rf_addr;
        wr_data_p0 = rf_wd;
        if (scrubbing) begin
            wr_vld_p0  = 1'b1;
            wr_addr_p0 = scrub_idx;
            wr_data_p0 = '0;
        end else if (a_gnt) begin
            wr_vld_p0  = (a_addr != '0);
            wr_addr_p0 = a_addr;
            wr_data_p0 = a_data;
        end else if (b_gnt) begin
            wr_vld_p0  = (b_addr != '0);
            wr_addr_p0 = b_addr;
            wr_data_p0 = b_data;
        end
    end

    // Stage p1: registered write port towards the register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_wd   <= '0;
        end else begin
            rf_we   <= wr_vld_p0;
            rf_addr <= wr_addr_p0;
            rf_wd   <= wr_data_p0;
        end
    end

    // Reset to B so that A wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_b <= 1'b1;
        end else if (a_gnt || b_gnt) begin
            last_b <= b_gnt;
        end
    end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed scoreboard bench for regfile_write_ctrl; covers both the scrub and the
// no-scrub build depending on RFCTRL_SCRUB_EN.
module tb_regfile_write_ctrl;

    logic        clk;
    logic        reset;
    logic        a_req;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_gnt;
    logic        b_req;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_gnt;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wd;
    logic        busy;

`ifdef RFCTRL_SCRUB_EN
    localparam logic SCRUB_ON = 1'b1;
`else
    localparam logic SCRUB_ON = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic        chk_ad;
        logic [4:0]  addr;
        logic [31:0] wd;
    } wr_t;

    wr_t         exp_q[$];
    int          checks;
    int          failures;
    logic [4:0]  m_addr;
    logic [31:0] m_wd;
    logic        m_known;

    regfile_write_ctrl #(.NREGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wd(rf_wd), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rst_check(input logic ebusy);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_addr", 32'(rf_addr), 32'd0);
        chk("rst_rf_wd", rf_wd, 32'd0);
        chk("rst_a_gnt", 32'(a_gnt), 32'd0);
        chk("rst_b_gnt", 32'(b_gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'(ebusy));
        m_addr  = '0;
        m_wd    = '0;
        m_known = 1'b1;
        exp_q.delete();
    endtask

    // One clock cycle: check grants/busy, push the expected write, then compare it after the edge.
    task automatic cyc(input int sidx, input logic ea, input logic eb, input logic ebusy);
        wr_t         e;
        logic [4:0]  ad;
        logic [31:0] dt;
        #1;
        chk("a_gnt", 32'(a_gnt), 32'(ea));
        chk("b_gnt", 32'(b_gnt), 32'(eb));
        chk("busy", 32'(busy), 32'(ebusy));
        if (sidx > 0) begin
            m_addr  = 5'(sidx);
            m_wd    = '0;
            m_known = 1'b1;
            e = '{we: 1'b1, chk_ad: 1'b1, addr: m_addr, wd: m_wd};
        end else if (ea || eb) begin
            ad = ea ? a_addr : b_addr;
            dt = ea ? a_data : b_data;
            if (ad == 5'd0) begin
                m_known = 1'b0;
                e = '{we: 1'b0, chk_ad: 1'b0, addr: ad, wd: dt};
            end else begin
                m_addr  = ad;
                m_wd    = dt;
                m_known = 1'b1;
                e = '{we: 1'b1, chk_ad: 1'b1, addr: ad, wd: dt};
            end
        end else begin
            e = '{we: 1'b0, chk_ad: m_known, addr: m_addr, wd: m_wd};
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("rf_we", 32'(rf_we), 32'(e.we));
        if (e.chk_ad) begin
            chk("rf_addr", 32'(rf_addr), 32'(e.addr));
            chk("rf_wd", rf_wd, e.wd);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_addr   = '0;
        m_wd     = '0;
        m_known  = 1'b1;
        reset    = 1'b1;
        a_req = 1'b0; a_addr = '0; a_data = '0;
        b_req = 1'b0; b_addr = '0; b_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_check(SCRUB_ON);

        // Release reset with A already requesting: scrub first (if built), then A.
        reset  = 1'b0;
        a_req  = 1'b1;
        a_addr = 5'd5;
        a_data = 32'hDEADBEEF;
`ifdef RFCTRL_SCRUB_EN
        for (int k = 1; k <= 31; k++) cyc(k, 1'b0, 1'b0, 1'b1);
`endif
        cyc(0, 1'b1, 1'b0, 1'b0);
        a_req = 1'b0;
        cyc(0, 1'b0, 1'b0, 1'b0);

        // A was granted last, so a tie goes to B first.
        a_req = 1'b1; a_addr = 5'd3; a_data = 32'h0000_0333;
        b_req = 1'b1; b_addr = 5'd7; b_data = 32'h0000_0777;
        cyc(0, 1'b0, 1'b1, 1'b0);
        cyc(0, 1'b1, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b1, 1'b0);
        cyc(0, 1'b1, 1'b0, 1'b0);

        // Destination zero: granted but not written.
        a_req = 1'b0;
        b_addr = 5'd0; b_data = 32'h0000_1234;
        cyc(0, 1'b0, 1'b1, 1'b0);
        b_req = 1'b0;
        cyc(0, 1'b0, 1'b0, 1'b0);

        // Reset while a write sits on rf_*: discarded, grants gated during reset.
        a_req = 1'b1; a_addr = 5'd9; a_data = 32'h0000_55AA;
        cyc(0, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        rst_check(SCRUB_ON);
        @(posedge clk);
        #1;
        a_req = 1'b0;
        reset = 1'b0;

`ifdef RFCTRL_SCRUB_EN
        // Reset at scrub index 10, then the scrub restarts from 1.
        a_req = 1'b1; a_addr = 5'd12; a_data = 32'h0000_00CC;
        for (int k = 1; k <= 9; k++) cyc(k, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        rst_check(1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        a_req = 1'b0;
        for (int k = 1; k <= 31; k++) cyc(k, 1'b0, 1'b0, 1'b1);
`endif

        // Fresh priority state after reset: contention alternates A, B, A, B.
        a_req = 1'b1; a_addr = 5'd3; a_data = 32'h0000_0A03;
        b_req = 1'b1; b_addr = 5'd7; b_data = 32'h0000_0B07;
        cyc(0, 1'b1, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b1, 1'b0);
        cyc(0, 1'b1, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b1, 1'b0);

        // Fairness: A alone, then both -> B.
        b_req = 1'b0;
        a_addr = 5'd21; a_data = 32'hCAFE_0021;
        cyc(0, 1'b1, 1'b0, 1'b0);
        b_req = 1'b1; b_addr = 5'd22; b_data = 32'hCAFE_0022;
        cyc(0, 1'b0, 1'b1, 1'b0);
        a_req = 1'b0; b_req = 1'b0;
        cyc(0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
